// File: rtl/uart_ctrl_if.sv
// Bus-side signals of the UART slave: chip select, strobe, address/data and ready.
interface uart_ctrl_if #(
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32
);
    logic                   CS_;
    logic                   As_;
    logic                   RW;
    logic [WORD_ADDR_W-1:0] Addr;
    logic [WORD_DATA_W-1:0] WrData;
    logic [WORD_DATA_W-1:0] RdData;
    logic                   Rdy_;

    modport master (output CS_, As_, RW, Addr, WrData, input RdData, Rdy_);
    modport slave  (input CS_, As_, RW, Addr, WrData, output RdData, Rdy_);
endinterface

// File: rtl/uart_ctrl.sv
// UART slave: 8N1 TX/RX, STATUS (Addr[0]=0) and DATA (Addr[0]=1) registers, level IRQs.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO instead of the single holding register.
module uart_ctrl #(
    parameter int BIT_CYCLES = 2604
) (
    input  logic       clk,
    input  logic       reset,
    uart_ctrl_if.slave bus_if,
    output logic       IRQRx,
    output logic       IRQTx,
    input  logic       UartRX,
    output logic       UartTX
);
    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    // Start-bit countdown is shortened by the decision cycle so the sample lands mid-bit.
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic acc, wr_stat, wr_data;
    assign acc     = !bus_if.CS_ && !bus_if.As_;
    assign wr_stat = acc && !bus_if.RW && !bus_if.Addr[0];
    assign wr_data = acc && !bus_if.RW &&  bus_if.Addr[0];

    logic unused_bits;
    assign unused_bits = ^{bus_if.Addr[$bits(bus_if.Addr)-1:1], bus_if.WrData[31:8]};

    state_t          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_done, txbusy, txflag_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_done    = 1'b0;
        case (tx_state_q)
            S_IDLE: if (wr_data) begin
                tx_state_d = S_START;
                tx_cnt_d   = BIT_LAST;
                tx_idx_d   = '0;
                tx_shift_d = bus_if.WrData[7:0];
            end
            S_START: if (tx_cnt_q == '0) begin
                tx_state_d = S_DATA;
                tx_cnt_d   = BIT_LAST;
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            S_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d   = BIT_LAST;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_idx_d   = tx_idx_q + 3'd1;
                if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            S_STOP: if (tx_cnt_q == '0) begin
                tx_state_d = S_IDLE;
                tx_done    = 1'b1;
            end else tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        UartTX = 1'b1;
        case (tx_state_q)
            S_START: UartTX = 1'b0;
            S_DATA:  UartTX = tx_shift_q[0];
            default: UartTX = 1'b1;
        endcase
    end

    assign txbusy = tx_state_q != S_IDLE;

    logic [1:0]      rx_sync_q;
    state_t          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_idx_q, rx_idx_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_good, rx_bad, rxbusy, rx_line;

    assign rx_line = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state_q)
            S_IDLE: if (!rx_line) begin
                rx_state_d = S_START;
                rx_cnt_d   = HALF_LAST;
            end
            S_START: if (rx_cnt_q == '0) begin
                if (rx_line) rx_state_d = S_IDLE;
                else begin
                    rx_state_d = S_DATA;
                    rx_cnt_d   = BIT_LAST;
                    rx_idx_d   = '0;
                end
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            S_DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d   = BIT_LAST;
                rx_shift_d = {rx_line, rx_shift_q[7:1]};
                rx_idx_d   = rx_idx_q + 3'd1;
                if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            S_STOP: if (rx_cnt_q == '0) begin
                rx_state_d = S_IDLE;
                rx_good    = rx_line;
                rx_bad     = !rx_line;
            end else rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_state_d = S_IDLE;
        endcase
    end

    assign rxbusy = rx_state_q != S_IDLE;

    logic       ovr_set, rxflag, ferr_q, ovr_q;
    logic [7:0] rx_head;

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q;
    logic       fifo_empty, fifo_full, pop, push, rd_data;

    assign rd_data    = acc && bus_if.RW && bus_if.Addr[0];
    assign fifo_empty = count_q == 3'd0;
    assign fifo_full  = count_q == 3'd4;
    assign pop        = rd_data && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push       = rx_good && (!fifo_full || pop);
    assign ovr_set    = rx_good && fifo_full && !pop;
    assign rxflag     = !fifo_empty;
    assign rx_head    = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= rx_shift_q;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_q + {2'b00, push} - {2'b00, pop};
        end
    end
`else
    logic [7:0] rx_hold_q;
    logic       rxflag_q;

    assign ovr_set = rx_good && rxflag_q;
    assign rxflag  = rxflag_q;
    assign rx_head = rx_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_hold_q <= '0;
            rxflag_q  <= 1'b0;
        end else begin
            if (rx_good) rx_hold_q <= rx_shift_q;
            rxflag_q <= rx_good | (rxflag_q & ~(wr_stat & bus_if.WrData[0]));
        end
    end
`endif

    logic [31:0] rd_val;
    assign rd_val = bus_if.Addr[0] ? {24'h0, rx_head}
                                   : {26'h0, ovr_q, ferr_q, txbusy, rxbusy, txflag_q, rxflag};

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q    <= S_IDLE;
            tx_cnt_q      <= '0;
            tx_idx_q      <= '0;
            tx_shift_q    <= '0;
            rx_sync_q     <= 2'b11;
            rx_state_q    <= S_IDLE;
            rx_cnt_q      <= '0;
            rx_idx_q      <= '0;
            rx_shift_q    <= '0;
            txflag_q      <= 1'b0;
            ferr_q        <= 1'b0;
            ovr_q         <= 1'b0;
            bus_if.RdData <= '0;
            bus_if.Rdy_   <= 1'b1;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_idx_q      <= tx_idx_d;
            tx_shift_q    <= tx_shift_d;
            rx_sync_q     <= {rx_sync_q[0], UartRX};
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_idx_q      <= rx_idx_d;
            rx_shift_q    <= rx_shift_d;
            txflag_q      <= tx_done | (txflag_q & ~(wr_stat & bus_if.WrData[1]));
            ferr_q        <= rx_bad  | (ferr_q   & ~(wr_stat & bus_if.WrData[4]));
            ovr_q         <= ovr_set | (ovr_q    & ~(wr_stat & bus_if.WrData[5]));
            bus_if.RdData <= (acc && bus_if.RW) ? rd_val : 32'h0;
            bus_if.Rdy_   <= !acc;
        end
    end

    assign IRQRx = rxflag;
    assign IRQTx = txflag_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl (BIT_CYCLES=16) against a frame-level UART model.
module tb_uart_ctrl;
    localparam int BC = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic IRQRx, IRQTx, UartTX;
    logic UartRX = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rx_lat;

    // Reference model: received bytes as the CPU should see them.
    logic [7:0] m_fifo[$];
    logic [7:0] m_hold = 8'h00;
    logic       m_flag = 1'b0;
    logic       m_ovr  = 1'b0;

    uart_ctrl_if bus_if ();

    uart_ctrl #(.BIT_CYCLES(BC)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus_if),
        .IRQRx  (IRQRx),
        .IRQTx  (IRQTx),
        .UartRX (UartRX),
        .UartTX (UartTX)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status(input logic ferr, input logic txbusy,
                                               input logic rxbusy, input logic txflag);
        logic rxf;
`ifdef UART_RX_FIFO_EN
        rxf = (m_fifo.size() != 0);
`else
        rxf = m_flag;
`endif
        return {26'h0, m_ovr, ferr, txbusy, rxbusy, txflag, rxf};
    endfunction

    task automatic model_deliver(input logic [7:0] b);
`ifdef UART_RX_FIFO_EN
        if (m_fifo.size() < 4) m_fifo.push_back(b);
        else m_ovr = 1'b1;
`else
        if (m_flag) m_ovr = 1'b1;
        m_hold = b;
        m_flag = 1'b1;
`endif
    endtask

    task automatic model_read(output logic [7:0] b);
`ifdef UART_RX_FIFO_EN
        if (m_fifo.size() != 0) b = m_fifo.pop_front();
        else b = 8'h00;
`else
        b = m_hold;
`endif
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_hold = 8'h00;
        m_flag = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic bus_cycle(input logic rw, input logic a0, input logic [31:0] wd,
                             output logic [31:0] rd, output logic rdy0,
                             output logic [31:0] rd1, output logic rdy1);
        @(posedge clk); #1;
        bus_if.CS_ = 1'b0; bus_if.As_ = 1'b0; bus_if.RW = rw;
        bus_if.Addr = {29'h0, a0}; bus_if.WrData = wd;
        @(posedge clk); #1;
        bus_if.CS_ = 1'b1; bus_if.As_ = 1'b1; bus_if.RW = 1'b1;
        @(negedge clk); rd = bus_if.RdData; rdy0 = bus_if.Rdy_;
        @(negedge clk); rd1 = bus_if.RdData; rdy1 = bus_if.Rdy_;
    endtask

    task automatic status_write(input logic [31:0] wd);
        logic [31:0] d0, d1; logic r0, r1;
        bus_cycle(1'b0, 1'b0, wd, d0, r0, d1, r1);
        if (wd[5]) m_ovr = 1'b0;
`ifndef UART_RX_FIFO_EN
        if (wd[0]) m_flag = 1'b0;
`endif
    endtask

    task automatic tx_frame(input logic [7:0] b, input logic chk_irq);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        @(posedge clk); #1;
        bus_if.CS_ = 1'b0; bus_if.As_ = 1'b0; bus_if.RW = 1'b0;
        bus_if.Addr = 30'h1; bus_if.WrData = {24'h0, b};
        @(posedge clk); #1;
        bus_if.CS_ = 1'b1; bus_if.As_ = 1'b1; bus_if.RW = 1'b1;
        for (int k = 0; k < 10 * BC; k++) begin
            @(negedge clk);
            checks++;
            if (UartTX !== fr[k / BC]) begin
                errors++;
                $display("FAIL tx_bit byte=%h cycle=%0d got %b exp %b", b, k, UartTX, fr[k / BC]);
            end
            if (chk_irq && k == 10 * BC - 1) begin
                checks++;
                if (IRQTx !== 1'b0) begin
                    errors++;
                    $display("FAIL tx_irq_early got %b exp 0", IRQTx);
                end
            end
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            UartRX = fr[j];
            repeat (BC - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        UartRX = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d0, d1; logic r0, r1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({UartTX, bus_if.Rdy_, IRQRx, IRQTx} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outputs got tx,rdy,irqrx,irqtx=%b exp 1100",
                     {UartTX, bus_if.Rdy_, IRQRx, IRQTx});
        end
        checks++;
        if (bus_if.RdData !== 32'h0) begin
            errors++;
            $display("FAIL reset_rddata got %h exp 0", bus_if.RdData);
        end
        bus_cycle(1'b1, 1'b0, 32'h0, d0, r0, d1, r1);
        checks++;
        if (d0 !== exp_status(1'b0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_status got %h exp %h", d0, exp_status(1'b0, 1'b0, 1'b0, 1'b0));
        end
        checks++;
        if ({r0, r1} !== 2'b01 || d1 !== 32'h0) begin
            errors++;
            $display("FAIL rdy_pulse got rdy=%b%b rd_after=%h exp 01 0", r0, r1, d1);
        end
    endtask

    task automatic test_tx();
        logic [31:0] d0, d1; logic r0, r1;
        fork
            tx_frame(8'hA5, 1'b1);
            begin
                repeat (30) @(negedge clk);
                bus_cycle(1'b1, 1'b0, 32'h0, d0, r0, d1, r1);
                checks++;
                if (d0 !== exp_status(1'b0, 1'b1, 1'b0, 1'b0)) begin
                    errors++;
                    $display("FAIL tx_busy_status got %h exp %h", d0,
                             exp_status(1'b0, 1'b1, 1'b0, 1'b0));
                end
                bus_cycle(1'b0, 1'b1, 32'h5A, d0, r0, d1, r1);
            end
        join
        @(negedge clk);
        checks++;
        if (IRQTx !== 1'b1 || UartTX !== 1'b1) begin
            errors++;
            $display("FAIL tx_done got irqtx=%b tx=%b exp 1 1", IRQTx, UartTX);
        end
        bus_cycle(1'b1, 1'b0, 32'h0, d0, r0, d1, r1);
        checks++;
        if (d0 !== exp_status(1'b0, 1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL tx_flag_status got %h exp %h", d0, exp_status(1'b0, 1'b0, 1'b0, 1'b1));
        end
        status_write(32'h2);
        checks++;
        if (IRQTx !== 1'b0) begin
            errors++;
            $display("FAIL tx_irq_clear got %b exp 0", IRQTx);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) tx_frame(8'($urandom), 1'b0);
        @(negedge clk);
        checks++;
        if (IRQTx !== 1'b1) begin
            errors++;
            $display("FAIL b2b_irq got %b exp 1", IRQTx);
        end
        status_write(32'h2);
    endtask

    task automatic test_rx();
        logic [31:0] d0, d1, s0, s1; logic r0, r1, q0, q1;
        logic [7:0] b, eb;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'h3C : 8'($urandom);
            rx_lat = -1;
            fork
                rx_send(b, 1'b1);
                begin
                    @(posedge clk); #1;
                    for (int c = 0; c < 300; c++) begin
                        @(negedge clk);
                        if (IRQRx === 1'b1) begin
                            rx_lat = c;
                            break;
                        end
                    end
                end
                begin
                    repeat (80) @(negedge clk);
                    bus_cycle(1'b1, 1'b0, 32'h0, s0, q0, s1, q1);
                    checks++;
                    if (s0 !== exp_status(1'b0, 1'b0, 1'b1, 1'b0)) begin
                        errors++;
                        $display("FAIL rx_busy_status got %h exp %h", s0,
                                 exp_status(1'b0, 1'b0, 1'b1, 1'b0));
                    end
                end
            join
            model_deliver(b);
            checks++;
            if (rx_lat < 153 || rx_lat > 157) begin
                errors++;
                $display("FAIL rx_latency byte=%h got %0d exp 155", b, rx_lat);
            end
            checks++;
            if (IRQRx !== 1'b1) begin
                errors++;
                $display("FAIL rx_irq got %b exp 1", IRQRx);
            end
            bus_cycle(1'b1, 1'b1, 32'h0, d0, r0, d1, r1);
            model_read(eb);
            checks++;
            if (d0 !== {24'h0, eb} || {r0, r1} !== 2'b01) begin
                errors++;
                $display("FAIL rx_data got %h rdy=%b%b exp %h rdy=01", d0, r0, r1, eb);
            end
            status_write(32'h1);
            checks++;
            if (IRQRx !== 1'b0) begin
                errors++;
                $display("FAIL rx_irq_clear got %b exp 0", IRQRx);
            end
        end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d0, d1; logic r0, r1;
        @(posedge clk); #1;
        UartRX = 1'b0;
        repeat (5) @(posedge clk);
        #1 UartRX = 1'b1;
        repeat (30) @(posedge clk);
        bus_cycle(1'b1, 1'b0, 32'h0, d0, r0, d1, r1);
        checks++;
        if (d0 !== exp_status(1'b0, 1'b0, 1'b0, 1'b0) || IRQRx !== 1'b0) begin
            errors++;
            $display("FAIL rx_glitch got status=%h irq=%b exp %h 0", d0, IRQRx,
                     exp_status(1'b0, 1'b0, 1'b0, 1'b0));
        end
        rx_send(8'($urandom), 1'b0);
        bus_cycle(1'b1, 1'b0, 32'h0, d0, r0, d1, r1);
        checks++;
        if (d0 !== exp_status(1'b1, 1'b0, 1'b0, 1'b0) || IRQRx !== 1'b0) begin
            errors++;
            $display("FAIL rx_ferr got status=%h irq=%b exp %h 0", d0, IRQRx,
                     exp_status(1'b1, 1'b0, 1'b0, 1'b0));
        end
        status_write(32'h10);
        bus_cycle(1'b1, 1'b0, 32'h0, d0, r0, d1, r1);
        checks++;
        if (d0 !== exp_status(1'b0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL ferr_clear got %h exp %h", d0, exp_status(1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_overrun();
        logic [31:0] d0, d1; logic r0, r1;
        logic [7:0] eb;
        int n_reads;
        for (int i = 1; i <= 5; i++) begin
            rx_send(8'(i), 1'b1);
            model_deliver(8'(i));
        end
        bus_cycle(1'b1, 1'b0, 32'h0, d0, r0, d1, r1);
        checks++;
        if (d0 !== exp_status(1'b0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL ovr_status got %h exp %h", d0, exp_status(1'b0, 1'b0, 1'b0, 1'b0));
        end
`ifdef UART_RX_FIFO_EN
        n_reads = 5;
`else
        n_reads = 2;
`endif
        for (int i = 0; i < n_reads; i++) begin
            bus_cycle(1'b1, 1'b1, 32'h0, d0, r0, d1, r1);
            model_read(eb);
            checks++;
            if (d0 !== {24'h0, eb}) begin
                errors++;
                $display("FAIL ovr_read idx=%0d got %h exp %h", i, d0, eb);
            end
        end
        status_write(32'h21);
        bus_cycle(1'b1, 1'b0, 32'h0, d0, r0, d1, r1);
        checks++;
        if (d0 !== exp_status(1'b0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL ovr_clear got %h exp %h", d0, exp_status(1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d0, d1; logic r0, r1;
        @(posedge clk); #1;
        bus_if.CS_ = 1'b0; bus_if.As_ = 1'b0; bus_if.RW = 1'b0;
        bus_if.Addr = 30'h1; bus_if.WrData = 32'h0;
        @(posedge clk); #1;
        bus_if.CS_ = 1'b1; bus_if.As_ = 1'b1; bus_if.RW = 1'b1;
        repeat (60) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (UartTX !== 1'b0) begin
            errors++;
            $display("FAIL mid_tx_line got %b exp 0", UartTX);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (UartTX !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_tx got %b exp 1", UartTX);
        end
        bus_cycle(1'b1, 1'b0, 32'h0, d0, r0, d1, r1);
        checks++;
        if (d0 !== exp_status(1'b0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_status got %h exp %h", d0, exp_status(1'b0, 1'b0, 1'b0, 1'b0));
        end
        tx_frame(8'($urandom), 1'b1);
        @(negedge clk);
        checks++;
        if (IRQTx !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_tx_irq got %b exp 1", IRQTx);
        end
        status_write(32'h2);
    endtask

    initial begin
        bus_if.CS_ = 1'b1;
        bus_if.As_ = 1'b1;
        bus_if.RW = 1'b1;
        bus_if.Addr = '0;
        bus_if.WrData = '0;
        test_reset();
        test_tx();
        test_back_to_back();
        test_rx();
        test_rx_errors();
        test_overrun();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

UART slave for the shared SoC bus; occupies one chip-select slot alongside the ROM and GPIO slaves and is decoded by `bus` like any other slave. It provides one 8N1 transmitter and one receiver with a fixed baud divider, a status/data register pair and two level interrupt lines for the CPU IRQ vector.

## Interface
- `BIT_CYCLES`, default 2604: clock cycles per UART bit. Must be ≥ 4.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `CS_` in 1: chip select from `bus`, active low.
- `As_` in 1: address strobe, active low.
- `RW` in 1: 1 = `READ`, 0 = `WRITE`.
- `Addr` in `WORD_ADDR_W`: word address; only bit 0 is decoded.
- `WrData` in `WORD_DATA_W`: write data.
- `RdData` out `WORD_DATA_W`: read data.
- `Rdy_` out 1: access complete, active low.
- `IRQRx` out 1: receive interrupt, level.
- `IRQTx` out 1: transmit-done interrupt, level.
- `UartRX` in 1: serial input, asynchronous.
- `UartTX` out 1: serial output, idle high.

## Operation
- **Access qualification.** An access is accepted in any cycle with `CS_`=0 and `As_`=0.
- **Addr[0]=0: STATUS register.**
  - Read value: {26'b0, ovr, ferr, txbusy, rxbusy, txflag, rxflag}.
  - Write: each 1 in bits 0, 1, 4 or 5 clears the matching flag.
  - If a set and a clear of the same flag happen in the same cycle, the set wins.
- **Addr[0]=1: DATA register.**
  - Write: WrData[7:0] starts transmission only if txbusy=0. A write while busy is dropped silently.
  - Read: returns {24'b0, rx byte}.
- **TX FSM: IDLE → START → DATA → STOP → IDLE.**
  - Each bit is held exactly `BIT_CYCLES` cycles.
  - DATA sends 8 bits, LSB first.
  - txbusy=1 in every state except IDLE.
  - On leaving STOP, txflag is set.
- **RX front end.** `UartRX` passes through a 2-flop synchronizer. All RX logic uses only the synchronized value.
- **RX FSM: IDLE → START → DATA → STOP → IDLE.**
  - IDLE: a synchronized low moves to START and loads the counter with `BIT_CYCLES`/2.
  - START: at mid-bit, line still low → DATA; line high → IDLE (glitch rejected, nothing logged).
  - DATA: 8 samples taken `BIT_CYCLES` apart, shifted in LSB first.
  - STOP: sampled at mid-bit. High → byte delivered and rxflag set. Low → byte discarded, ferr set. Either way → IDLE.
  - rxbusy=1 in every state except IDLE.
- **Interrupts.** `IRQRx` = rxflag. `IRQTx` = txflag.
- **Counters.** Counter widths are `$clog2(BIT_CYCLES)+1`. The bit index is 3 bits and wraps 7→0 on exit from DATA.

## Timing
- **Reset values.** `RdData`=0, `Rdy_`=1, `UartTX`=1, `IRQRx`=0, `IRQTx`=0. Both FSMs go to IDLE, all flags clear, FIFO empty.
- **Reset mid-frame.** Takes effect at the next edge: `UartTX` returns high in the following cycle and any partial byte is lost.
- **Bus latency.** One cycle.
  - `Rdy_`=0 for exactly one cycle, the cycle after an accepted access.
  - `RdData` is valid only in that cycle and is 0 otherwise.
  - `Rdy_` is also pulsed for writes.
- **TX latency.** A DATA write accepted in cycle N gives `UartTX`=0 (start bit) from cycle N+1. txbusy reads 1 from cycle N+1.
- **Frame length.** A full TX frame is 10×`BIT_CYCLES` cycles. txflag is set in the cycle after the STOP bit ends.
- **RX latency.** rxflag rises 2 sync cycles + 9.5×`BIT_CYCLES` (±1) after the falling start edge on the pin.
- **Back-to-back TX.** A new byte can be accepted in the first cycle txbusy reads 0.

## Configuration
- **`UART_RX_FIFO_EN` defined: 4-entry RX FIFO.**
  - rxflag = FIFO not empty; a STATUS write to bit 0 has no effect.
  - A DATA read pops the head; a read when empty returns 0.
  - A byte arriving while the FIFO is full is dropped and sets ovr.
  - If a pop and a push happen in the same cycle when full, both succeed and ovr is not set.
- **`UART_RX_FIFO_EN` undefined: single holding register.**
  - A DATA read is non-destructive.
  - rxflag is cleared only through STATUS.
  - A new byte overwrites the holding register and sets ovr if rxflag was already 1.

## Test plan
Benches run with `BIT_CYCLES`=16.
1. **Reset.** Assert `reset` 2 cycles → `UartTX`=1, `Rdy_`=1, IRQs 0, STATUS read = 0x00.
2. **TX frame.** Write 0xA5 to DATA → `UartTX` pattern 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. txbusy=1 throughout; `IRQTx`=1 after 160 cycles. STATUS write 0x2 → `IRQTx`=0. A second write during busy → line unaffected.
3. **RX good byte.** Drive 0x3C 8N1 on `UartRX` → `IRQRx`=1. DATA read = 0x3C with `Rdy_` low one cycle after the access.
4. **RX errors.**
   - 5-cycle low glitch → stays IDLE, no flag.
   - Frame with stop=0 → ferr=1 (STATUS bit 4), rxflag=0.
5. **Overrun.**
   - FIFO build: send 5 bytes 0x01..0x05 without reading → reads return 0x01..0x04, then 0; ovr=1.
   - Non-FIFO build: same stimulus → DATA reads 0x05; ovr=1.
6. **Reset mid-TX.** Assert `reset` during DATA of a TX frame → `UartTX`=1 next cycle, txbusy=0, and a new write transmits cleanly.
